// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM (IF/ID/EX/MEM/WB/HALT) that sequences
//               the integer datapath around the ALU. It also owns the shared
//               memory handshake and halts on illegal opcodes or memory
//               timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [6:0] opCode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Equal,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWE,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [6:0] AluOpCode,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic [2:0] State,
    output logic       Illegal,
    output logic       BusErr
);

    localparam logic [2:0] c_ST_IF   = 3'd0;
    localparam logic [2:0] c_ST_ID   = 3'd1;
    localparam logic [2:0] c_ST_EX   = 3'd2;
    localparam logic [2:0] c_ST_MEM  = 3'd3;
    localparam logic [2:0] c_ST_WB   = 3'd4;
    localparam logic [2:0] c_ST_HALT = 3'd7;

    localparam logic [2:0] c_CL_ADDI = 3'd0;
    localparam logic [2:0] c_CL_SLLI = 3'd1;
    localparam logic [2:0] c_CL_SLT  = 3'd2;
    localparam logic [2:0] c_CL_LW   = 3'd3;
    localparam logic [2:0] c_CL_SW   = 3'd4;
    localparam logic [2:0] c_CL_BEQ  = 3'd5;
    localparam logic [2:0] c_CL_ILL  = 3'd7;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] r_cls;
    logic [7:0] r_cnt;
    logic       r_illegal;
    logic       r_buserr;
    logic [2:0] w_dec;
    logic       w_timeout;

    // Classify the instruction currently held in IR
    always_comb begin
        w_dec = c_CL_ILL;
        case (opCode)
            7'b0010011: begin
                if (funct3 == 3'b000)
                    w_dec = c_CL_ADDI;
                else if (funct3 == 3'b001 && funct7 == 7'd0)
                    w_dec = c_CL_SLLI;
            end
            7'b0110011: if (funct3 == 3'b010 && funct7 == 7'd0) w_dec = c_CL_SLT;
            7'b0000011: if (funct3 == 3'b010) w_dec = c_CL_LW;
            7'b0100011: if (funct3 == 3'b010) w_dec = c_CL_SW;
            7'b1100011: if (funct3 == 3'b000) w_dec = c_CL_BEQ;
            default:    w_dec = c_CL_ILL;
        endcase
    end

    // Wait budget exhausted: this cycle takes priority over a late MemReady
    assign w_timeout = (r_cnt == c_TIMEOUT);

    // State sequencing, wait counter and sticky error flags
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_ST_IF;
            r_cls     <= c_CL_ADDI;
            r_cnt     <= 8'd0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IF: begin
                    if (w_timeout) begin
                        r_buserr <= 1'b1;
                        r_state  <= c_ST_HALT;
                    end else if (MemReady) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_ST_ID;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_ID: begin
                    if (w_dec == c_CL_ILL) begin
                        r_illegal <= 1'b1;
                        r_state   <= c_ST_HALT;
                    end else if (w_dec == c_CL_BEQ) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_ST_IF;
                    end else begin
                        r_cls   <= w_dec;
                        r_state <= c_ST_EX;
                    end
                end
                c_ST_EX: begin
                    if (r_cls == c_CL_LW || r_cls == c_CL_SW) begin
                        r_cnt   <= 8'd0;
                        r_state <= c_ST_MEM;
                    end else begin
                        r_state <= c_ST_WB;
                    end
                end
                c_ST_MEM: begin
                    if (w_timeout) begin
                        r_buserr <= 1'b1;
                        r_state  <= c_ST_HALT;
                    end else if (MemReady) begin
                        r_cnt   <= 8'd0;
                        r_state <= (r_cls == c_CL_LW) ? c_ST_WB : c_ST_IF;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_WB: begin
                    r_cnt   <= 8'd0;
                    r_state <= c_ST_IF;
                end
                c_ST_HALT: r_state <= c_ST_HALT;
                default:   r_state <= c_ST_HALT;
            endcase
        end
    end

    // Control strobes decoded from state and class; Reset forces all low at once
    always_comb begin
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 2'b00;
        AluOpCode = 7'd0;
        ALUOp     = 3'b000;
        ALUSrcB   = 1'b0;
        RegWrite  = 1'b0;
        MemToReg  = 1'b0;
        if (!Reset) begin
            case (r_state)
                c_ST_IF: begin
                    MemReq = 1'b1;
                    if (MemReady && !w_timeout) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                c_ST_ID: begin
                    if (w_dec == c_CL_BEQ) begin
                        PCWrite = Equal;
                        PCSrc   = 2'b01;
                    end
                end
                c_ST_EX: begin
                    case (r_cls)
                        c_CL_SLLI: begin
                            AluOpCode = 7'b0010011;
                            ALUOp     = 3'b001;
                            ALUSrcB   = 1'b1;
                        end
                        c_CL_SLT: begin
                            AluOpCode = 7'b0110011;
                            ALUOp     = 3'b010;
                            ALUSrcB   = 1'b0;
                        end
                        default: begin
                            AluOpCode = 7'b0010011;
                            ALUOp     = 3'b000;
                            ALUSrcB   = 1'b1;
                        end
                    endcase
                end
                c_ST_MEM: begin
                    MemReq = 1'b1;
                    IorD   = 1'b1;
                    MemWE  = (r_cls == c_CL_SW);
                end
                c_ST_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = (r_cls == c_CL_LW);
                end
                default: ;
            endcase
        end
    end

    assign State   = r_state;
    assign Illegal = r_illegal;
    assign BusErr  = r_buserr;

endmodule
`default_nettype wire
